// File: rtl/cnn_mul_rr_arbiter_if.sv
// Requester/consumer bundle for the shared conv multiplier arbiter.
// The master side drives requests and accepts responses; the arbiter is the slave.
interface cnn_mul_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 20,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*din0_WIDTH-1:0] req_a;
  logic [NUM_REQ*din1_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rsp_valid;
  logic [ID_W-1:0]               rsp_id;
  logic [dout_WIDTH-1:0]         rsp_p;
  logic                          rsp_ready;
  logic                          busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/cnn_mul_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined 14x6 signed*unsigned multiplier
// between NUM_REQ conv channels; products return tagged with the requester index.
module cnn_mul_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 20,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  cnn_mul_rr_arbiter_if.slave  bus
);

  logic [ID_W-1:0]       r_ptr;
  logic [NUM_STAGE-1:0]  r_vld;
  logic [ID_W-1:0]       r_id [NUM_STAGE];

  logic                  w_stall;
  logic                  w_found;
  logic                  w_accept;
  logic [ID_W-1:0]       w_idx;
  logic [ID_W-1:0]       w_gnt;
  logic [ID_W-1:0]       w_ptr_nxt;
  logic [din0_WIDTH-1:0] w_sel_a;
  logic [din1_WIDTH-1:0] w_sel_b;
  logic [dout_WIDTH-1:0] w_rsp_p;

  // Sign-extend A, zero-extend B, keep the low dout_WIDTH bits: exact two's complement product.
  function automatic logic [dout_WIDTH-1:0] f_mul(input logic [din0_WIDTH-1:0] a,
                                                  input logic [din1_WIDTH-1:0] b);
    logic [dout_WIDTH-1:0] ext_a;
    logic [dout_WIDTH-1:0] ext_b;
    ext_a = {{(dout_WIDTH-din0_WIDTH){a[din0_WIDTH-1]}}, a};
    ext_b = {{(dout_WIDTH-din1_WIDTH){1'b0}}, b};
    return ext_a * ext_b;
  endfunction

  assign w_stall   = r_vld[NUM_STAGE-1] & ~bus.rsp_ready;
  assign w_accept  = w_found & ~w_stall & ~ap_rst;
  assign w_ptr_nxt = (w_gnt == ID_W'(NUM_REQ-1)) ? '0 : w_gnt + 1'b1;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == w_gnt) begin
        w_sel_a = bus.req_a[k*din0_WIDTH +: din0_WIDTH];
        w_sel_b = bus.req_b[k*din1_WIDTH +: din1_WIDTH];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_accept) bus.req_ready[w_gnt] = 1'b1;
  end

  // NOTE: sequential state uses <= so every stage samples pre-edge values and shifts in lockstep.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_ptr <= '0;
      r_vld <= '0;
      for (int k = 0; k < NUM_STAGE; k++) r_id[k] <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= w_accept;
      r_id[0]  <= w_gnt;
      for (int k = 1; k < NUM_STAGE; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_id[k]  <= r_id[k-1];
      end
      if (w_accept) r_ptr <= w_ptr_nxt;
    end
  end

  generate
    if (NUM_STAGE == 1) begin : g_single
      logic [dout_WIDTH-1:0] r_p;
      always_ff @(posedge ap_clk) begin
        if (ap_rst)        r_p <= '0;
        else if (w_accept) r_p <= f_mul(w_sel_a, w_sel_b);
      end
      assign w_rsp_p = r_p;
    end else begin : g_multi
      logic [din0_WIDTH-1:0] r_a;
      logic [din1_WIDTH-1:0] r_b;
      logic [dout_WIDTH-1:0] r_p [1:NUM_STAGE-1];

      // NOTE: operand registers carry no reset; r_vld[0] qualifies them, so reset fanout is saved.
      always_ff @(posedge ap_clk) begin
        if (w_accept) begin
          r_a <= w_sel_a;
          r_b <= w_sel_b;
        end
      end

      // Product stages load only behind a valid entry so rsp_p holds its last value across bubbles.
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int k = 1; k < NUM_STAGE; k++) r_p[k] <= '0;
        end else if (!w_stall) begin
          if (r_vld[0]) r_p[1] <= f_mul(r_a, r_b);
          for (int k = 2; k < NUM_STAGE; k++) begin
            if (r_vld[k-1]) r_p[k] <= r_p[k-1];
          end
        end
      end
      assign w_rsp_p = r_p[NUM_STAGE-1];
    end
  endgenerate

  assign bus.rsp_valid = r_vld[NUM_STAGE-1];
  assign bus.rsp_id    = r_id[NUM_STAGE-1];
  assign bus.rsp_p     = w_rsp_p;
  assign bus.busy      = |r_vld;

endmodule
